sbox_keystream_gen: RTL
=======================

Name: sbox_keystream_gen

Overview:
- Byte-serial keystream generator and XOR stage for the AES-S-box-based stream cipher.
- Sits directly upstream of the combinational S-box LUT (`sbox_lut`): it keeps a 16-byte NLFSR state, drives S-box lookups each step, and consumes their results.
- Results feed back into the state and become the keystream byte.
- Keystream is XORed with a valid/ready plaintext byte stream to produce a ciphertext stream. The same block decrypts.

Parameters:
- WARMUP_STEPS, 32, number of state-update steps run after init before any keystream is released (0 allowed).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- init  input  1  single-cycle pulse: load state from key and iv, then start warm-up.
- key  input  128  key; byte i = key[8i+7:8i].
- iv  input  128  initialisation vector; byte i = iv[8i+7:8i].
- in_valid  input  1  plaintext byte valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  8  plaintext (or ciphertext) byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  8  in_data XOR keystream byte.
- busy  output  1  high during WARMUP.

Behaviour:
- Reset and clock: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, S[0..15]=0, warm-up counter=0, out_valid=0, out_data=0, busy=0, in_ready=0.
- Step function, all on pre-step values:
  - a = SBOX(S[3]); b = SBOX(S[0]^S[13]).
  - z = a^S[10].
  - fb = b^S[7].
  - Then S[i]<=S[i+1] for i=0..14, and S[15]<=fb.
- FSM states: IDLE, WARMUP, RUN.
- IDLE: in_ready=0. On init go to WARMUP, or to RUN if WARMUP_STEPS==0.
- init handling (in any state):
  - S[i]<=key byte i ^ iv byte i.
  - Warm-up counter <= 0.
  - out_valid<=0.
  - init has priority over rst=0 activity but not over rst.
- WARMUP:
  - One step per cycle; z is discarded; busy=1; in_ready=0.
  - After exactly WARMUP_STEPS steps, go to RUN. busy falls in the cycle RUN is entered.
- RUN:
  - in_ready = !out_valid || out_ready.
  - On in_valid && in_ready: perform one step, out_data<=in_data^z, out_valid<=1. The state advances only on an accepted byte.
  - If out_valid && out_ready and no new byte is accepted: out_valid<=0.
  - Simultaneous accept-in and drain-out: out_valid stays 1 with new data, so throughput is 1 byte/cycle.
- Latency: one cycle from input accept to out_valid.
- Output hold: out_data and out_valid are held stable while out_valid && !out_ready.
- init mid-stream drops any pending output byte; the ciphertext stream restarts.
- rst mid-operation: all reset values apply next cycle, regardless of init.
- No wrap-around or counter limit in RUN; the stream is unbounded.

Decomposition:
- Shared package `sbox_cipher_pkg` holds:
  - the state enum (IDLE/WARMUP/RUN);
  - localparams STATE_BYTES=16 and the tap indices (0, 3, 7, 10, 13);
  - a byte typedef.
- Two instances of the existing combinational S-box LUT submodule (`sbox_lut`) supply SBOX. No other submodule is needed.

Test Plan:
- Reset and handshake: rst for 2 cycles with in_valid=1 → out_valid=0, in_ready=0, busy=0, out_data=0x00 throughout.
- Zero key/iv with WARMUP_STEPS=0: init, then 8 plaintext bytes 0x00 with out_ready=1 → out_data = 0x63 ×6, then 0x00, 0x00, at 1 byte/cycle.
- Warm-up timing with WARMUP_STEPS=32: after the init pulse, busy=1 for exactly 32 cycles and in_ready=0 over that span. in_ready=1 in the cycle after busy falls.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 → in_ready drops after the first accept, out_data is held, and no step is lost. The resulting stream equals the no-stall stream.
- Round trip: random key/iv/plaintext run through two instances (encrypt, then decrypt with the same key/iv) → output equals the original plaintext for 1000 bytes.
- init mid-stream (after 3 bytes, with out_valid=1 and out_ready=0) → out_valid clears next cycle. The subsequent stream equals a fresh-init stream.

Source files
------------

// File: rtl/sbox_cipher_pkg.sv
// Shared types and constants for the S-box based stream cipher.
// Holds the controller state enum, the NLFSR geometry and the tap positions
// used by the keystream step function.
package sbox_cipher_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam int STATE_BYTES = 16;

    // Tap positions into the 16-byte NLFSR state.
    localparam int TAP_SB_B0 = 0;   // XORed with TAP_SB_B1 to address the feedback S-box
    localparam int TAP_SB_A  = 3;   // addresses the keystream S-box
    localparam int TAP_FB    = 7;   // linear term of the feedback byte
    localparam int TAP_Z     = 10;  // linear term of the keystream byte
    localparam int TAP_SB_B1 = 13;

endpackage

// File: rtl/sbox_lut.sv
// AES forward S-box as a purely combinational 256-entry lookup.
// Latency: combinational, zero cycles.
// Backpressure: none, no handshake.
// Ports: addr_i - input byte; data_o - SBOX(addr_i).
module sbox_lut (
    input  logic [7:0] addr_i,
    output logic [7:0] data_o
);

    // Entry 0 sits in the most significant byte, so the table reads row by row
    // in the usual 0x00..0xff order.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // ~addr_i == 255 - addr_i selects the byte counted from the MSB end.
    assign data_o = SBOX_TABLE[{~addr_i, 3'b000} +: 8];

endmodule

// File: rtl/sbox_keystream_gen.sv
// Byte-serial NLFSR keystream generator that XORs the keystream onto a byte stream.
// Latency: one cycle from input accept to out_valid; throughput one byte per cycle.
// Backpressure: in_ready = !out_valid || out_ready in RUN; output is held while stalled.
//
// Ports:
//   clk, rst        - clock (rising edge), synchronous active-high reset
//   init, key, iv   - init pulse loads S[i] = key byte i ^ iv byte i, then warms up
//   in_valid/in_ready/in_data    - plaintext (or ciphertext) byte input
//   out_valid/out_ready/out_data - in_data XOR keystream byte
//   busy            - high while warm-up steps are running
module sbox_keystream_gen
    import sbox_cipher_pkg::*;
#(
    parameter int WARMUP_STEPS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init,
    input  logic [8*STATE_BYTES-1:0] key,
    input  logic [8*STATE_BYTES-1:0] iv,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     busy
);

    localparam int CW = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;
    // The counter holds the index of the warm-up step in progress; the step
    // with index WARMUP_STEPS-1 is the last one before RUN.
    localparam logic [CW-1:0] WCNT_LAST = CW'((WARMUP_STEPS > 0) ? WARMUP_STEPS - 1 : 0);

    typedef byte_t state_t [STATE_BYTES];

    state_e        state_q, state_d;
    state_t        s_q, s_d, s_step;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          out_valid_q, out_valid_d;
    byte_t         out_data_q, out_data_d;

    byte_t sb_a_addr, sb_b_addr, sb_a, sb_b;
    byte_t z, fb;
    logic  accept;

    assign sb_a_addr = s_q[TAP_SB_A];
    assign sb_b_addr = s_q[TAP_SB_B0] ^ s_q[TAP_SB_B1];

    sbox_lut u_sbox_a (
        .addr_i (sb_a_addr),
        .data_o (sb_a)
    );

    sbox_lut u_sbox_b (
        .addr_i (sb_b_addr),
        .data_o (sb_b)
    );

    assign z  = sb_a ^ s_q[TAP_Z];
    assign fb = sb_b ^ s_q[TAP_FB];

    // Post-step state; only committed when the controller decides to step.
    always_comb begin
        for (int i = 0; i < STATE_BYTES - 1; i++) begin
            s_step[i] = s_q[i + 1];
        end
        s_step[STATE_BYTES - 1] = fb;
    end

    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == WARMUP);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        wcnt_d      = wcnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (init) begin
            // init overrides any handshake in the same cycle; a byte offered
            // alongside init is not consumed into the new stream.
            for (int i = 0; i < STATE_BYTES; i++) begin
                s_d[i] = key[8*i +: 8] ^ iv[8*i +: 8];
            end
            wcnt_d      = '0;
            out_valid_d = 1'b0;
            state_d     = (WARMUP_STEPS == 0) ? RUN : WARMUP;
        end else begin
            case (state_q)
                WARMUP: begin
                    s_d = s_step;
                    if (wcnt_q == WCNT_LAST) begin
                        state_d = RUN;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        s_d         = s_step;
                        out_data_d  = in_data ^ z;
                        out_valid_d = 1'b1;
                    end else if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    // IDLE waits for init.
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < STATE_BYTES; i++) begin
                s_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            s_q         <= s_d;
        end
    end

endmodule
